// File: rtl/line_mem_responder.sv
// Line-store responder for the 128-bit cache line channel: queued line reads/writes served
// in order from a block-RAM store, with read responses returned after LATENCY extra cycles.
module line_mem_responder #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req_en,
  input  logic         i_req_cmd,
  input  logic [26:0]  i_req_addr,
  input  logic [127:0] i_req_data,
  output logic         o_req_rdy,
  output logic         o_rsp_en,
  output logic [127:0] o_rsp_data,
  input  logic         i_rsp_rdy,
  output logic         o_busy,
  output logic         o_overflow
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned Lines = 1 << ADDR_W;
  localparam logic [7:0]  LatM1 = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  state_e              r_state, w_state_d;
  logic [PtrW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]     r_count, w_count_d;
  logic                r_full, r_empty, r_overflow;
  logic                r_cmd_rd;
  logic [ADDR_W-1:0]   r_cmd_idx;
  logic [127:0]        r_cmd_data;
  logic [7:0]          r_cnt, w_cnt_d;
  logic [127:0]        r_rsp_data;
  logic [127:0]        r_ram_q;

  logic                r_fifo_cmd  [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_fifo_idx  [FIFO_DEPTH];
  logic [127:0]        r_fifo_data [FIFO_DEPTH];
  logic [127:0]        r_mem       [Lines];

  logic                w_push, w_pop, w_ram_we, w_capture;
  logic [ADDR_W-1:0]   w_rd_idx;
  logic                w_unused_addr;

  assign w_unused_addr = ^i_req_addr;
  assign w_push        = i_req_en & ~r_full;

  // Reads are addressed at the pop edge so the RAM output is already valid during ACCESS.
  assign w_rd_idx = w_pop ? r_fifo_idx[r_rd_ptr] : r_cmd_idx;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_pop     = 1'b0;
    w_ram_we  = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!r_empty) begin
          w_pop     = 1'b1;
          w_state_d = StAccess;
        end
      end
      StAccess: begin
        if (!r_cmd_rd) begin
          w_ram_we  = 1'b1;
          w_state_d = StIdle;
        end else if (LATENCY == 0) begin
          w_capture = 1'b1;
          w_state_d = StResp;
        end else begin
          w_cnt_d   = LatM1;
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_state_d = StResp;
        end else begin
          w_cnt_d = r_cnt - 8'd1;
        end
      end
      StResp: begin
        if (i_rsp_rdy) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop)      w_count_d = r_count + CntW'(1);
    else if (!w_push && w_pop) w_count_d = r_count - CntW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_cmd_rd   <= 1'b0;
      r_cmd_idx  <= '0;
      r_cmd_data <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_count <= w_count_d;
      r_full  <= (w_count_d == CntW'(FIFO_DEPTH));
      r_empty <= (w_count_d == '0);
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (i_req_en && r_full) r_overflow <= 1'b1;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PtrW'(1);
        r_cmd_rd   <= r_fifo_cmd[r_rd_ptr];
        r_cmd_idx  <= r_fifo_idx[r_rd_ptr];
        r_cmd_data <= r_fifo_data[r_rd_ptr];
      end
      if (w_capture) r_rsp_data <= r_ram_q;
    end
  end

  // Queue storage and line store carry no reset; RAM contents survive rst.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_cmd[r_wr_ptr]  <= i_req_cmd;
      r_fifo_idx[r_wr_ptr]  <= i_req_addr[ADDR_W+3:4];
      r_fifo_data[r_wr_ptr] <= i_req_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_ram_we) r_mem[r_cmd_idx] <= r_cmd_data;
    r_ram_q <= r_mem[w_rd_idx];
  end

  assign o_req_rdy  = ~r_full;
  assign o_rsp_en   = (r_state == StResp);
  assign o_rsp_data = r_rsp_data;
  assign o_busy     = ~r_empty | (r_state != StIdle);
  assign o_overflow = r_overflow;

endmodule
